// File: rtl/ifm_bank_load_ctrl_pkg.sv
// Shared constants and state encoding for the IFM bank load sequencer.
// LOAD_CHECKSUM_EN (optional) adds an XOR checksum of the written words.
package layer_load_pkg;

    localparam int NUM_BANKS      = 16;
    localparam int WORDS_PER_BANK = 128;
    localparam int ADDR_W         = 9;
    localparam int DATA_W         = 128;
    localparam int BIAS_W         = 16;
    localparam int NUM_BIAS       = 4;
    localparam int IFM_WORDS      = NUM_BANKS * WORDS_PER_BANK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } load_state_e;

endpackage

// File: rtl/ifm_bank_load_ctrl_if.sv
// Stream, BRAM write port and layer control bundle for ifm_bank_load_ctrl.
// oChecksum exists only when LOAD_CHECKSUM_EN is defined.
interface ifm_bank_load_ctrl_if import layer_load_pkg::*; ();

    logic                         iLoadReq;
    logic [NUM_BIAS*BIAS_W-1:0]   iBias;
    logic                         iAbort;
    logic [DATA_W-1:0]            iData;
    logic                         iValid;
    logic                         oReady;
    logic [NUM_BANKS-1:0]         o_ena;
    logic [NUM_BANKS-1:0]         o_wea;
    logic [ADDR_W-1:0]            o_addra;
    logic [DATA_W-1:0]            o_dia;
    logic [NUM_BIAS*BIAS_W-1:0]   oBias;
    logic                         oStart;
    logic                         iLayerDone;
    logic                         oBusy;
`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0]            oChecksum;
`endif

    modport master (
`ifdef LOAD_CHECKSUM_EN
        input  oChecksum,
`endif
        output iLoadReq, iBias, iAbort, iData, iValid, iLayerDone,
        input  oReady, o_ena, o_wea, o_addra, o_dia, oBias, oStart, oBusy
    );

    modport slave (
`ifdef LOAD_CHECKSUM_EN
        output oChecksum,
`endif
        input  iLoadReq, iBias, iAbort, iData, iValid, iLayerDone,
        output oReady, o_ena, o_wea, o_addra, o_dia, oBias, oStart, oBusy
    );

endinterface

// File: rtl/ifm_bank_load_ctrl.sv
// Fills the layer's IFM banks bank-major from a valid/ready stream, then starts the layer.
// LOAD_CHECKSUM_EN adds oChecksum, the XOR of every word written in the current fill.
module ifm_bank_load_ctrl import layer_load_pkg::*; (
    input  logic                 clk,
    input  logic                 rstn,
    ifm_bank_load_ctrl_if.slave  bus
);

    load_state_e                r_state;
    logic [NUM_BANKS-1:0]       r_bank_oh;
    logic [ADDR_W-1:0]          r_word;
    logic [NUM_BANKS-1:0]       r_ena;
    logic [ADDR_W-1:0]          r_addra;
    logic [DATA_W-1:0]          r_dia;
    logic [NUM_BIAS*BIAS_W-1:0] r_bias;
    logic                       r_ready;
    logic                       r_start;
    logic                       r_busy;

    logic w_hs;
    logic w_last_word;
    logic w_last_bank;

    assign w_hs        = bus.iValid & r_ready;
    assign w_last_word = (r_word == ADDR_W'(WORDS_PER_BANK - 1));
    assign w_last_bank = r_bank_oh[NUM_BANKS-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_bank_oh <= '0;
            r_word    <= '0;
            r_ena     <= '0;
            r_addra   <= '0;
            r_dia     <= '0;
            r_bias    <= '0;
            r_ready   <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ena   <= '0;
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.iLoadReq) begin
                        r_state   <= ST_FILL;
                        r_bias    <= bus.iBias;
                        r_bank_oh <= NUM_BANKS'(1);
                        r_word    <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (bus.iAbort) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_hs) begin
                        r_ena   <= r_bank_oh;
                        r_addra <= r_word;
                        r_dia   <= bus.iData;
                        // The final word goes straight to START so the start pulse
                        // lines up with the last write strobe; counters never wrap.
                        if (w_last_word && w_last_bank) begin
                            r_state <= ST_START;
                            r_ready <= 1'b0;
                            r_start <= 1'b1;
                        end else if (w_last_word) begin
                            r_word    <= '0;
                            r_bank_oh <= r_bank_oh << 1;
                        end else begin
                            r_word <= r_word + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.iLayerDone) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oReady  = r_ready;
    assign bus.o_ena   = r_ena;
    assign bus.o_wea   = r_ena;
    assign bus.o_addra = r_addra;
    assign bus.o_dia   = r_dia;
    assign bus.oBias   = r_bias;
    assign bus.oStart  = r_start;
    assign bus.oBusy   = r_busy;

`ifdef LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_checksum <= '0;
        end else if (r_state == ST_IDLE && bus.iLoadReq) begin
            r_checksum <= '0;
        end else if (r_state == ST_FILL && !bus.iAbort && w_hs) begin
            r_checksum <= r_checksum ^ bus.iData;
        end
    end

    assign bus.oChecksum = r_checksum;
`endif

endmodule
